log2_wrapper: RTL and testbench

//  Inverse of the exp component: streaming 8-bit log2 encoder for the HUBERT softmax/normalise path.

---
 rtl/log2_wrapper.sv | 145 ++++++++++++++
 tb/tb_log2_wrapper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/log2_wrapper.sv
// rtl/log2_wrapper.sv - streaming 8-bit log2 encoder with credit-tracked output FIFO
// Optional LOG2_WRAPPER_STATS_EN adds saturating accept/stall counters.
module log2_wrapper #(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  bin_in,
  input  logic        ivalid,
  output logic        oready,
  output logic [7:0]  bin_out,
  output logic        bin_zero,
  output logic        ovalid,
  input  logic        iready
`ifdef LOG2_WRAPPER_STATS_EN
  ,
  output logic [31:0] stat_accepted,
  output logic [31:0] stat_stalled
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic             accept;
  logic             push;
  logic             pop;
  logic [2:0]       lead;
  logic [7:0]       norm;

  logic             s1_v_q;
  logic [2:0]       s1_lead_q;
  logic [7:0]       s1_norm_q;
  logic             s2_v_q;
  logic [8:0]       s2_data_q;

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [8:0]       head_q, head_d;
  logic             ovalid_q, ovalid_d;
  logic [CRD_W-1:0] credits;

  assign accept  = ivalid & oready;
  assign push    = s2_v_q;
  assign pop     = ovalid_q & iready;
  assign credits = CRD_W'(s1_v_q) + CRD_W'(s2_v_q) + CRD_W'(count_q);
  assign oready  = (credits < CRD_W'(FIFO_DEPTH));

  // Normalise so the leading one lands on bit 7; zero input stays all-zero.
  always_comb begin
    lead = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bin_in[i]) lead = 3'(i);
    end
    norm = bin_in << (3'd7 - lead);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_lead_q <= 3'd0;
      s1_norm_q <= 8'd0;
      s2_v_q    <= 1'b0;
      s2_data_q <= 9'd0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_lead_q <= lead;
        s1_norm_q <= norm;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) s2_data_q <= {~s1_norm_q[7], s1_lead_q, s1_norm_q[6:2]};
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= s2_data_q;
  end

  // Head register holds the last popped entry while the FIFO is empty.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ovalid_d = (count_d != '0);
    head_d   = head_q;
    if (ovalid_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = s2_data_q;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 9'd0;
      ovalid_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign ovalid   = ovalid_q;
  assign bin_out  = head_q[7:0];
  assign bin_zero = head_q[8];

  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    !(push && (count_q == CNT_W'(FIFO_DEPTH)) && !pop));

`ifdef LOG2_WRAPPER_STATS_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    acc_d   = acc_q;
    stall_d = stall_q;
    if (accept && (acc_q != 32'hFFFF_FFFF)) acc_d = acc_q + 32'd1;
    if (ivalid && !oready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q   <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      acc_q   <= acc_d;
      stall_q <= stall_d;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_stalled  = stall_q;
`endif

endmodule

// File: tb/tb_log2_wrapper.sv
// tb/tb_log2_wrapper.sv - scoreboard bench for log2_wrapper
module tb_log2_wrapper;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] bin_in;
  logic       ivalid;
  logic       oready;
  logic [7:0] bin_out;
  logic       bin_zero;
  logic       ovalid;
  logic       iready;
`ifdef LOG2_WRAPPER_STATS_EN
  logic [31:0] stat_accepted;
  logic [31:0] stat_stalled;
`endif

  int errors = 0;
  int checks = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_stall = 0;
  int max_out = 0;
  logic [8:0] sb [$];

  log2_wrapper #(.FIFO_DEPTH(4), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .bin_in(bin_in), .ivalid(ivalid),
    .oready(oready), .bin_out(bin_out), .bin_zero(bin_zero),
    .ovalid(ovalid), .iready(iready)
`ifdef LOG2_WRAPPER_STATS_EN
    , .stat_accepted(stat_accepted), .stat_stalled(stat_stalled)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] ref_log2(input logic [7:0] x);
    int e;
    logic [4:0] m;
    if (x == 8'd0) return 9'h100;
    e = 7;
    while (!x[e]) e--;
    m = 5'd0;
    for (int k = 0; k < 5; k++) begin
      if (e - 1 - k >= 0) m[4-k] = x[e-1-k];
    end
    return {1'b0, 3'(e), m};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop before push so an output is never matched against a sample accepted this cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (ovalid && iready) begin
        n_out++;
        if (sb.size() == 0) check("sb_unexpected_output", 32'(n_out), 32'(n_acc));
        else check("sb_data", 32'({bin_zero, bin_out}), 32'(sb.pop_front()));
      end
      if (ivalid && oready) begin
        sb.push_back(ref_log2(bin_in));
        n_acc++;
      end
      if (ivalid && !oready) n_stall++;
      if (n_acc - n_out > max_out) max_out = n_acc - n_out;
    end
  end

  task automatic send_lat(input logic [7:0] x, input logic [8:0] exp, input string tag);
    int lat;
    @(posedge clock); #1;
    bin_in = x;
    ivalid = 1'b1;
    @(negedge clock);
    check({tag, "_oready"}, 32'(oready), 32'd1);
    @(posedge clock); #1;
    ivalid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!ovalid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_data"}, 32'({bin_zero, bin_out}), 32'(exp));
  endtask

  task automatic stream(input int n, input logic [7:0] base, input int budget, input bit tog,
                        output int taken, output int cycles);
    taken = 0;
    cycles = 0;
    @(posedge clock); #1;
    while (taken < n && cycles < budget) begin
      bin_in = base + 8'(taken);
      ivalid = 1'b1;
      @(negedge clock);
      if (oready) taken++;
      @(posedge clock); #1;
      cycles++;
      if (tog) iready = ~iready;
    end
    ivalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while ((sb.size() != 0 || ovalid) && c < 200) begin
      @(negedge clock);
      c++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_in_out"}, 32'(n_out), 32'(n_acc));
  endtask

  initial begin
    int taken, cycles, st0, out0;
    reset = 1'b1;
    ivalid = 1'b0;
    iready = 1'b1;
    bin_in = 8'd0;
    repeat (3) @(posedge clock);
    #2;
    check("rst_ovalid", 32'(ovalid), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_bin_zero", 32'(bin_zero), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_oready", 32'(oready), 32'd1);

    // T1 / T2: single samples with exact latency
    send_lat(8'h01, 9'h000, "t1_01");
    send_lat(8'h05, 9'h048, "t1_05");
    send_lat(8'h40, 9'h0C0, "t1_40");
    send_lat(8'hFF, 9'h0FF, "t1_ff");
    send_lat(8'h00, 9'h100, "t2_zero");
    @(negedge clock);
    check("t2_one_cycle", 32'(ovalid), 32'd0);

    // T3: backpressure fills exactly FIFO_DEPTH credits
    iready = 1'b0;
    stream(8, 8'h10, 12, 1'b0, taken, cycles);
    check("t3_taken", 32'(taken), 32'd4);
    @(negedge clock);
    check("t3_oready_low", 32'(oready), 32'd0);
    check("t3_ovalid", 32'(ovalid), 32'd1);
    @(posedge clock); #1;
    iready = 1'b1;
    @(negedge clock);
    check("t3_head", 32'({bin_zero, bin_out}), 32'h080);
    stream(4, 8'h14, 20, 1'b0, taken, cycles);
    check("t3_rest", 32'(taken), 32'd4);
    drain("t3");

    // T4: full-rate streaming
    st0 = n_stall;
    out0 = n_out;
    stream(256, 8'h00, 300, 1'b0, taken, cycles);
    check("t4_cycles", 32'(cycles), 32'd256);
    check("t4_no_stall", 32'(n_stall), 32'(st0));
    drain("t4");
    check("t4_outputs", 32'(n_out - out0), 32'd256);

    // T5: fill, then push/pop at full with iready toggling
    iready = 1'b0;
    stream(4, 8'hA0, 10, 1'b0, taken, cycles);
    stream(24, 8'hB0, 100, 1'b1, taken, cycles);
    check("t5_taken", 32'(taken), 32'd24);
    iready = 1'b1;
    drain("t5");
    check("t5_max_outstanding", 32'(max_out <= 4), 32'd1);

    // T6: reset with buffered samples
    iready = 1'b0;
    stream(3, 8'h30, 10, 1'b0, taken, cycles);
    repeat (3) @(negedge clock);
    check("t6_buffered", 32'(ovalid), 32'd1);
`ifdef LOG2_WRAPPER_STATS_EN
    check("t6_stat_acc_pre", stat_accepted, 32'(n_acc));
    check("t6_stat_stall_pre", stat_stalled, 32'(n_stall));
`endif
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("t6_ovalid_async", 32'(ovalid), 32'd0);
    sb.delete();
    n_out = n_acc;
`ifdef LOG2_WRAPPER_STATS_EN
    check("t6_stat_acc", stat_accepted, 32'd0);
    check("t6_stat_stall", stat_stalled, 32'd0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t6_oready", 32'(oready), 32'd1);
    check("t6_empty", 32'(ovalid), 32'd0);
    iready = 1'b1;
    send_lat(8'h02, 9'h020, "t6_02");
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
